ntt_poly_unloader: RTL and testbench
====================================

Name: ntt_poly_unloader

Overview:
- Read-side counterpart of the NTT input loader. The loader serializes a poly_t into the NTT core one coefficient per cycle, index 0 first.
- This block issues the single-cycle read request to the NTT core and captures the serial 12-bit coefficient stream (dout).
- It reassembles the stream into a full polynomial and presents that polynomial to the linear-operation controller with a valid/ready handshake.
- It sits between the NTT core's output port and the poly_t operand/result registers of the linear-operation module.

Parameters:
- N_COEFF, 256, number of coefficients per polynomial.
- COEFF_W, 12, coefficient width in bits.
- RD_LAT, 2, cycles from the rd_o cycle to coefficient 0 on dout_i; legal range 1..15.
- Q, 3329, modulus; used only when the optional feature is compiled in.

Ports:
- clk_i, in, 1, clock; all logic is on the rising edge.
- rst_i, in, 1, reset; asynchronous, active-high.
- start_i, in, 1, single-cycle request to unload one polynomial from the NTT core.
- rd_o, out, 1, single-cycle read strobe to the NTT core.
- dout_i, in, COEFF_W, serial coefficient stream from the NTT core.
- poly_o, out, N_COEFF*COEFF_W, reassembled polynomial; coefficient k is at [k*COEFF_W +: COEFF_W].
- valid_o, out, 1, poly_o holds a complete polynomial.
- ready_i, in, 1, consumer accepts poly_o.
- busy_o, out, 1, high in every state except IDLE.
- overrun_o, out, 1, sticky flag: start_i was dropped.

Behaviour:
- Reset, asynchronous on rst_i high:
  - State goes to IDLE.
  - rd_o, valid_o, busy_o and overrun_o go to 0; poly_o goes to all zero.
  - Latency and coefficient counters clear.
  - Reset asserted mid-operation aborts the transfer. No partial polynomial is ever flagged valid.
- States: IDLE, REQ, WAIT_LAT, CAPTURE, HOLD.
  - IDLE: start_i=1 -> REQ.
  - REQ: lasts exactly one cycle with rd_o=1 (rd_o is registered, never combinational). Then -> WAIT_LAT, latency counter loaded with RD_LAT-1.
  - WAIT_LAT: decrement the counter; at 0 -> CAPTURE. If RD_LAT=1, go REQ -> CAPTURE directly.
  - CAPTURE:
    - Every cycle, poly_o <= {dout_i, poly_o[N_COEFF*COEFF_W-1:COEFF_W]}, i.e. shift right and insert at the top.
    - The coefficient counter (9 bits wide for N_COEFF=256) increments each cycle.
    - After the N_COEFF-th capture -> HOLD. The first received coefficient then ends up at index 0.
  - HOLD:
    - valid_o=1 and poly_o is stable.
    - valid_o&&ready_i -> IDLE, and valid_o is 0 the next cycle.
    - If start_i=1 in the same cycle as the handshake, go -> REQ instead (back-to-back unload).
- Latency: start_i in cycle c gives rd_o in cycle c+1, coefficient 0 sampled in cycle c+1+RD_LAT, valid_o first high in cycle c+1+RD_LAT+N_COEFF (c+259 at defaults).
- start_i is ignored and overrun_o is set (sticky until reset) when it arrives:
  - in REQ, WAIT_LAT or CAPTURE;
  - in HOLD without ready_i.
- ready_i outside HOLD has no effect.
- dout_i is sampled only in CAPTURE; its value at any other time is don't-care.
- poly_o is not cleared on handshake; it holds the last polynomial until the next CAPTURE begins overwriting it.

Optional Feature:
- Macro: NTT_UNLOAD_CSUB_EN.
- Defined:
  - Each captured coefficient passes one conditional subtraction before the shift: if dout_i >= Q, store dout_i - Q, else store dout_i, truncated to COEFF_W bits.
  - Combinational only; latency is unchanged.
- Undefined: dout_i is stored unmodified.

Test Plan:
- Basic unload, RD_LAT=2: pulse start_i at cycle 0; drive dout_i = k (k=0..255) starting cycle 3 -> rd_o high only in cycle 1; valid_o rises in cycle 259; poly_o[k]=k; busy_o high cycles 1..259 until accept.
- Hold and back-to-back: keep ready_i=0 for 10 cycles after valid_o -> poly_o stable, valid_o stays 1. Assert ready_i and start_i together -> rd_o next cycle; second stream dout_i=255-k yields poly_o[k]=255-k; overrun_o stays 0.
- Overrun: start_i pulse during CAPTURE (cycle 100) -> no second rd_o; overrun_o=1 from cycle 101 and stays set after the handshake.
- Reset mid-CAPTURE: assert rst_i asynchronously at cycle 150 -> all outputs 0 immediately, state IDLE. A new start_i gives a clean full unload with no valid_o from the aborted transfer.
- RD_LAT=1 build: start_i at cycle 0 -> coefficient 0 sampled in cycle 2; valid_o first high in cycle 258.
- With NTT_UNLOAD_CSUB_EN: dout_i values 3328, 3329, 4095, 0 in slots 0..3 -> poly_o[0..3] = 3328, 0, 766, 0. Without the macro, the same stream gives 3328, 3329, 4095, 0.

Source files
------------

// File: rtl/ntt_poly_unloader.sv
// rtl/ntt_poly_unloader.sv - NTT core read-out: serial coefficient stream to poly_t with valid/ready (optional NTT_UNLOAD_CSUB_EN)
module ntt_poly_unloader #(
    parameter int N_COEFF = 256,
    parameter int COEFF_W = 12,
    parameter int RD_LAT  = 2,
    parameter int Q       = 3329
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    output logic                         rd_o,
    input  logic [COEFF_W-1:0]           dout_i,
    output logic [N_COEFF*COEFF_W-1:0]   poly_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic                         busy_o,
    output logic                         overrun_o
);

    localparam int PW    = N_COEFF * COEFF_W;
    localparam int CNT_W = $clog2(N_COEFF + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_COEFF - 1);
    localparam logic [3:0]       LAT_INIT = 4'(RD_LAT - 1);

    // Elaboration-time guards on the configuration.
    if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_lat
        $error("ntt_poly_unloader: RD_LAT must be in 1..15");
    end
    if (Q < 1 || Q >= (1 << COEFF_W)) begin : g_bad_q
        $error("ntt_poly_unloader: Q must be representable in COEFF_W bits");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_LAT,
        S_CAPTURE,
        S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         lat_q, lat_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]      poly_q, poly_d;
    logic               rd_q, rd_d;
    logic               ovr_q, ovr_d;
    logic [COEFF_W-1:0] coeff_in;

`ifdef NTT_UNLOAD_CSUB_EN
    localparam logic [COEFF_W:0] Q_EXT = (COEFF_W + 1)'(Q);
    logic [COEFF_W:0] dout_ext;
    logic [COEFF_W:0] dout_sub;

    // One conditional subtraction folds [Q, 2^COEFF_W) back into range.
    always_comb begin
        dout_ext = {1'b0, dout_i};
        dout_sub = dout_ext - Q_EXT;
        coeff_in = (dout_ext >= Q_EXT) ? dout_sub[COEFF_W-1:0] : dout_i;
    end
`else
    assign coeff_in = dout_i;
`endif

    // Next-state logic: sequencing, capture shift register, overrun detection.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        cnt_d   = cnt_q;
        poly_d  = poly_q;
        ovr_d   = ovr_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_REQ;
            end
            S_REQ: begin
                if (start_i) ovr_d = 1'b1;
                cnt_d   = '0;
                lat_d   = LAT_INIT;
                state_d = (RD_LAT == 1) ? S_CAPTURE : S_WAIT_LAT;
            end
            S_WAIT_LAT: begin
                if (start_i) ovr_d = 1'b1;
                lat_d = lat_q - 4'd1;
                if (lat_q <= 4'd1) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (start_i) ovr_d = 1'b1;
                // Shift right, newest at the top: first coefficient lands at index 0.
                poly_d = {coeff_in, poly_q[PW-1:COEFF_W]};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (ready_i) begin
                    state_d = start_i ? S_REQ : S_IDLE;
                end else if (start_i) begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        rd_d = (state_d == S_REQ);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
            cnt_q   <= '0;
            poly_q  <= '0;
            rd_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            cnt_q   <= cnt_d;
            poly_q  <= poly_d;
            rd_q    <= rd_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rd_o      = rd_q;
    assign poly_o    = poly_q;
    assign valid_o   = (state_q == S_HOLD);
    assign busy_o    = (state_q != S_IDLE);
    assign overrun_o = ovr_q;

endmodule

// File: tb/tb_ntt_poly_unloader.sv
// tb/tb_ntt_poly_unloader.sv - self-checking bench for ntt_poly_unloader
module tb_ntt_poly_unloader;

    localparam int N      = 256;
    localparam int W      = 12;
    localparam int RD_LAT = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           ready = 1'b0;
    logic [W-1:0]   dout = '0;
    logic           rd, valid, busy, ovr;
    logic [N*W-1:0] poly;

    ntt_poly_unloader #(.N_COEFF(N), .COEFF_W(W), .RD_LAT(RD_LAT), .Q(3329)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .rd_o     (rd),
        .dout_i   (dout),
        .poly_o   (poly),
        .valid_o  (valid),
        .ready_i  (ready),
        .busy_o   (busy),
        .overrun_o(ovr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [W-1:0] stream [N];
    logic [W-1:0] expp   [N];
    int rd_cyc   = -1000;
    int rd_count = 0;

    // NTT core model: coefficient idx appears RD_LAT+idx cycles after the read strobe.
    always @(negedge clk) begin
        int idx;
        if (rd === 1'b1) begin
            rd_cyc = cyc;
            rd_count++;
        end
        idx = cyc - rd_cyc - RD_LAT;
        if (idx >= 0 && idx < N) dout = stream[idx];
        else dout = W'($urandom);
    end

    function automatic logic [W-1:0] ref_csub(input logic [W-1:0] x);
`ifdef NTT_UNLOAD_CSUB_EN
        if (int'(x) >= 3329) return W'(int'(x) - 3329);
`endif
        return x;
    endfunction

    function automatic logic [W-1:0] pc(input int k);
        return poly[k*W +: W];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic calc_exp;
        for (int k = 0; k < N; k++) expp[k] = ref_csub(stream[k]);
    endtask

    task automatic set_stream(input int mode);
        for (int k = 0; k < N; k++) begin
            case (mode)
                0:       stream[k] = W'(k);
                1:       stream[k] = W'(255 - k);
                default: stream[k] = W'($urandom);
            endcase
        end
        calc_exp();
    endtask

    task automatic check_poly(input string name);
        int bad = -1;
        for (int k = 0; k < N; k++)
            if (bad < 0 && pc(k) !== expp[k]) bad = k;
        if (bad < 0) chk(name, 32'(pc(0)), 32'(expp[0]));
        else chk($sformatf("%s[%0d]", name, bad), 32'(pc(bad)), 32'(expp[bad]));
    endtask

    task automatic do_start(output int c0);
        start = 1'b1;
        c0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int c0, input bit rand_ready);
        int nb = 0;
        bit ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (busy !== 1'b1) nb++;
            if (rand_ready) ready = 1'($urandom);
            tick();
        end
        ready = 1'b0;
        if (ok) chk({name, " valid cycle"}, 32'(cyc), 32'(c0 + 1 + RD_LAT + N));
        else chk({name, " valid timeout"}, 32'(valid), 32'd1);
        chk({name, " busy gaps"}, 32'(nb), 32'd0);
    endtask

    task automatic accept(input string name);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk({name, " valid after accept"}, 32'(valid), 32'd0);
        chk({name, " busy after accept"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vt [8];

    initial begin
        int c0;
        int rdc;
        int bad;
        logic [N*W-1:0] snap;

`ifdef NTT_UNLOAD_CSUB_EN
        vt[0] = '{12'd3328, 12'd3328}; vt[1] = '{12'd3329, 12'd0};
        vt[2] = '{12'd4095, 12'd766};  vt[3] = '{12'd0,    12'd0};
        vt[4] = '{12'd1,    12'd1};    vt[5] = '{12'd3330, 12'd1};
        vt[6] = '{12'd2048, 12'd2048}; vt[7] = '{12'd4094, 12'd765};
`else
        vt[0] = '{12'd3328, 12'd3328}; vt[1] = '{12'd3329, 12'd3329};
        vt[2] = '{12'd4095, 12'd4095}; vt[3] = '{12'd0,    12'd0};
        vt[4] = '{12'd1,    12'd1};    vt[5] = '{12'd3330, 12'd3330};
        vt[6] = '{12'd2048, 12'd2048}; vt[7] = '{12'd4094, 12'd4094};
`endif
        for (int k = 0; k < N; k++) stream[k] = '0;

        // Reset state.
        tick(); tick(); tick();
        chk("reset rd", 32'(rd), 32'd0);
        chk("reset valid", 32'(valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset overrun", 32'(ovr), 32'd0);
        chk("reset poly zero", 32'(poly == '0), 32'd1);
        #2 rst = 1'b0;
        tick();

        // Basic unload, stream k.
        set_stream(0);
        rdc = rd_count;
        do_start(c0);
        wait_valid("basic", c0, 1'b0);
        chk("basic rd count", 32'(rd_count - rdc), 32'd1);
        chk("basic rd cycle", 32'(rd_cyc), 32'(c0 + 1));
        check_poly("basic poly");
        chk("basic overrun", 32'(ovr), 32'd0);

        // Hold for 10 cycles with ready low.
        snap = poly;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid !== 1'b1 || poly !== snap) bad++;
        end
        chk("hold stable", 32'(bad), 32'd0);

        // Back-to-back: handshake and start together.
        set_stream(1);
        rdc = rd_count;
        start = 1'b1;
        ready = 1'b1;
        c0 = cyc;
        tick();
        start = 1'b0;
        ready = 1'b0;
        chk("b2b valid drop", 32'(valid), 32'd0);
        chk("b2b rd", 32'(rd), 32'd1);
        wait_valid("b2b", c0, 1'b0);
        chk("b2b rd count", 32'(rd_count - rdc), 32'd1);
        check_poly("b2b poly");
        chk("b2b overrun", 32'(ovr), 32'd0);
        accept("b2b");

        // Overrun: start during CAPTURE.
        set_stream(2);
        rdc = rd_count;
        do_start(c0);
        while (cyc < c0 + 100) tick();
        chk("ovr before", 32'(ovr), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ovr set", 32'(ovr), 32'd1);
        wait_valid("ovr", c0, 1'b0);
        chk("ovr rd count", 32'(rd_count - rdc), 32'd1);
        check_poly("ovr poly");
        accept("ovr");
        chk("ovr sticky", 32'(ovr), 32'd1);

        // Asynchronous reset mid-CAPTURE.
        set_stream(2);
        do_start(c0);
        while (cyc < c0 + 150) tick();
        #2 rst = 1'b1;
        #1;
        chk("arst rd", 32'(rd), 32'd0);
        chk("arst valid", 32'(valid), 32'd0);
        chk("arst busy", 32'(busy), 32'd0);
        chk("arst overrun", 32'(ovr), 32'd0);
        chk("arst poly zero", 32'(poly == '0), 32'd1);
        tick(); tick();
        #2 rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("arst no stale valid", 32'(bad), 32'd0);
        set_stream(2);
        do_start(c0);
        wait_valid("post-rst", c0, 1'b0);
        check_poly("post-rst poly");
        chk("post-rst overrun", 32'(ovr), 32'd0);
        accept("post-rst");

        // Table-driven boundary coefficients in slots 0..7.
        set_stream(2);
        for (int i = 0; i < 8; i++) stream[i] = vt[i].din;
        calc_exp();
        do_start(c0);
        wait_valid("table", c0, 1'b0);
        for (int i = 0; i < 8; i++)
            chk($sformatf("table coeff %0d", i), 32'(pc(i)), 32'(vt[i].exp));
        check_poly("table poly");
        accept("table");

        // Random streams, ready toggled outside HOLD, random hold time.
        for (int r = 0; r < 3; r++) begin
            set_stream(2);
            do_start(c0);
            wait_valid($sformatf("rand%0d", r), c0, 1'b1);
            check_poly($sformatf("rand%0d poly", r));
            bad = 0;
            for (int i = 0; i < int'($urandom_range(4, 0)); i++) begin
                tick();
                if (valid !== 1'b1) bad++;
            end
            chk($sformatf("rand%0d hold", r), 32'(bad), 32'd0);
            accept($sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
